// File: rtl/rx_buf_malloc.sv
`default_nettype none
// ============================================================================
// Module  : rx_buf_malloc
// Purpose : Allocates and reclaims fixed-size RX payload buffers using a
//           circular FIFO of free buffer indices.
// Revision: 1.0  initial release
// ============================================================================
module rx_buf_malloc #(
    parameter int NUM_BUFS      = 64,
    parameter int BUF_BYTES     = 2048,
    parameter int BUF_IDX_W     = $clog2(NUM_BUFS),
    parameter int RX_BUF_ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_pipe_rx_malloc_req_val,
    output logic                     rx_malloc_rx_pipe_req_rdy,
    output logic                     rx_malloc_rx_pipe_resp_val,
    input  logic                     rx_pipe_rx_malloc_resp_rdy,
    output logic                     rx_malloc_rx_pipe_resp_ok,
    output logic [RX_BUF_ADDR_W-1:0] rx_malloc_rx_pipe_resp_addr,
    input  logic                     app_rx_free_req_val,
    output logic                     rx_malloc_app_free_req_rdy,
    input  logic [RX_BUF_ADDR_W-1:0] app_rx_free_req_addr,
    output logic [BUF_IDX_W:0]       rx_malloc_free_cnt,
    output logic                     rx_malloc_init_done,
    output logic                     rx_malloc_err
);

    localparam int                       BUF_SHIFT = $clog2(BUF_BYTES);
    localparam logic [BUF_IDX_W:0]       FULL_CNT  = (BUF_IDX_W+1)'(NUM_BUFS);
    localparam logic [BUF_IDX_W:0]       CNT_ONE   = (BUF_IDX_W+1)'(1);
    localparam logic [BUF_IDX_W-1:0]     IDX_ONE   = BUF_IDX_W'(1);
    localparam logic [BUF_IDX_W-1:0]     LAST_IDX  = BUF_IDX_W'(NUM_BUFS-1);
    localparam logic [RX_BUF_ADDR_W-1:0] OFF_MASK  = RX_BUF_ADDR_W'(BUF_BYTES-1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [BUF_IDX_W-1:0]       head_q, head_d;
    logic [BUF_IDX_W-1:0]       tail_q, tail_d;
    logic [BUF_IDX_W-1:0]       init_idx_q, init_idx_d;
    logic [BUF_IDX_W:0]         count_q, count_d;
    logic                       init_done_q, init_done_d;
    logic                       err_q, err_d;
    logic                       resp_ok_q, resp_ok_d;
    logic [RX_BUF_ADDR_W-1:0]   resp_addr_q, resp_addr_d;

    logic [BUF_IDX_W-1:0]       fifo_mem [NUM_BUFS];

    logic                       w_free_fire;
    logic                       w_free_ok;
    logic                       w_free_push;
    logic                       w_alloc_fire;
    logic                       w_alloc_pop;
    logic                       w_push;
    logic [BUF_IDX_W-1:0]       w_push_idx;
    logic [BUF_IDX_W-1:0]       w_pop_idx;

    assign rx_malloc_rx_pipe_req_rdy   = (state_q == ST_READY);
    assign rx_malloc_rx_pipe_resp_val  = (state_q == ST_RESP);
    assign rx_malloc_app_free_req_rdy  = (state_q != ST_INIT);
    assign rx_malloc_rx_pipe_resp_ok   = resp_ok_q;
    assign rx_malloc_rx_pipe_resp_addr = resp_addr_q;
    assign rx_malloc_free_cnt          = count_q;
    assign rx_malloc_init_done         = init_done_q;
    assign rx_malloc_err               = err_q;

    // A free is only trusted if it names an in-range, aligned buffer and the list has room.
    assign w_free_fire  = app_rx_free_req_val && rx_malloc_app_free_req_rdy;
    assign w_free_ok    = ((app_rx_free_req_addr & OFF_MASK) == '0)
                       && ((app_rx_free_req_addr >> (BUF_SHIFT + BUF_IDX_W)) == '0)
                       && (count_q != FULL_CNT);
    assign w_free_push  = w_free_fire && w_free_ok;

    assign w_alloc_fire = rx_pipe_rx_malloc_req_val && rx_malloc_rx_pipe_req_rdy;
    assign w_alloc_pop  = w_alloc_fire && (count_q != '0);

    assign w_push       = (state_q == ST_INIT) || w_free_push;
    assign w_push_idx   = (state_q == ST_INIT) ? init_idx_q
                                               : app_rx_free_req_addr[BUF_SHIFT +: BUF_IDX_W];
    assign w_pop_idx    = fifo_mem[head_q];

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        init_idx_d  = init_idx_q;
        count_d     = count_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        resp_ok_d   = resp_ok_q;
        resp_addr_d = resp_addr_q;

        unique case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + IDX_ONE;
                if (init_idx_q == LAST_IDX) begin
                    init_done_d = 1'b1;
                    state_d     = ST_READY;
                end
            end
            ST_READY: begin
                if (w_alloc_fire) begin
                    state_d = ST_RESP;
                    if (w_alloc_pop) begin
                        resp_ok_d   = 1'b1;
                        resp_addr_d = RX_BUF_ADDR_W'(w_pop_idx) << BUF_SHIFT;
                        head_d      = head_q + IDX_ONE;
                    end else begin
                        resp_ok_d   = 1'b0;
                        resp_addr_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (rx_pipe_rx_malloc_resp_rdy) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (w_free_fire && !w_free_ok) begin
            err_d = 1'b1;
        end
        if (w_push) begin
            tail_d = tail_q + IDX_ONE;
        end

        unique case ({w_push, w_alloc_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            head_q      <= '0;
            tail_q      <= '0;
            init_idx_q  <= '0;
            count_q     <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            resp_ok_q   <= 1'b0;
            resp_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            init_idx_q  <= init_idx_d;
            count_q     <= count_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            resp_ok_q   <= resp_ok_d;
            resp_addr_q <= resp_addr_d;
        end
    end

    // Index storage needs no reset: INIT rewrites every slot before use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[tail_q] <= w_push_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_buf_malloc.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_buf_malloc
// Purpose : Directed + random bench for rx_buf_malloc against a queue model.
// Revision: 1.0  initial release
// ============================================================================
module tb_rx_buf_malloc;

    localparam int NB = 4;
    localparam int BB = 2048;
    localparam int IW = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic          resp_val;
    logic          resp_rdy = 1'b0;
    logic          resp_ok;
    logic [AW-1:0] resp_addr;
    logic          free_val = 1'b0;
    logic          free_rdy;
    logic [AW-1:0] free_addr = '0;
    logic [IW:0]   free_cnt;
    logic          init_done;
    logic          err;

    rx_buf_malloc #(
        .NUM_BUFS      (NB),
        .BUF_BYTES     (BB),
        .BUF_IDX_W     (IW),
        .RX_BUF_ADDR_W (AW)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .rx_pipe_rx_malloc_req_val   (req_val),
        .rx_malloc_rx_pipe_req_rdy   (req_rdy),
        .rx_malloc_rx_pipe_resp_val  (resp_val),
        .rx_pipe_rx_malloc_resp_rdy  (resp_rdy),
        .rx_malloc_rx_pipe_resp_ok   (resp_ok),
        .rx_malloc_rx_pipe_resp_addr (resp_addr),
        .app_rx_free_req_val         (free_val),
        .rx_malloc_app_free_req_rdy  (free_rdy),
        .app_rx_free_req_addr        (free_addr),
        .rx_malloc_free_cnt          (free_cnt),
        .rx_malloc_init_done         (init_done),
        .rx_malloc_err               (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of free buffer addresses in allocation order.
    int unsigned m_q[$];
    int          m_init_left;
    bit          m_busy;
    bit          m_ok;
    bit          m_err;
    int unsigned m_addr;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_init_left = NB;
        m_busy      = 1'b0;
        m_ok        = 1'b0;
        m_err       = 1'b0;
        m_addr      = 0;
    endfunction

    function automatic void model_step();
        int cnt0;
        if (m_init_left > 0) begin
            m_q.push_back(32'(NB - m_init_left) * BB);
            m_init_left--;
            return;
        end
        cnt0 = m_q.size();
        if (!m_busy && req_val) begin
            m_busy = 1'b1;
            if (cnt0 > 0) begin
                m_ok   = 1'b1;
                m_addr = m_q.pop_front();
            end else begin
                m_ok   = 1'b0;
                m_addr = 0;
            end
        end else if (m_busy && resp_rdy) begin
            m_busy = 1'b0;
        end
        if (free_val) begin
            if ((free_addr % BB) == 0 && free_addr < NB * BB && cnt0 < NB)
                m_q.push_back(free_addr);
            else
                m_err = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        check_val("init_done", init_done, m_init_left == 0);
        check_val("req_rdy",   req_rdy,   (m_init_left == 0) && !m_busy);
        check_val("free_rdy",  free_rdy,  m_init_left == 0);
        check_val("resp_val",  resp_val,  m_busy);
        check_val("free_cnt",  free_cnt,  m_q.size());
        check_val("err",       err,       m_err);
        if (m_busy) begin
            check_val("resp_ok",   resp_ok,   m_ok);
            check_val("resp_addr", resp_addr, m_addr);
        end
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_val   = 1'b0;
        resp_rdy  = 1'b0;
        free_val  = 1'b0;
        free_addr = '0;
    endtask

    // Reset lands between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        clear_inputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic alloc_one();
        req_val = 1'b1;
        cycle();
        req_val = 1'b0;
        cycle();
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;
    endtask

    task automatic free_one(input int unsigned a);
        free_val  = 1'b1;
        free_addr = a;
        cycle();
        free_val  = 1'b0;
    endtask

    task automatic alloc_with_free(input int unsigned a);
        req_val   = 1'b1;
        free_val  = 1'b1;
        free_addr = a;
        cycle();
        req_val  = 1'b0;
        free_val = 1'b0;
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        repeat (6) cycle();

        repeat (4) alloc_one();
        alloc_one();

        free_one(32'h1000);
        alloc_one();
        free_one(32'h0);
        free_one(32'h800);
        alloc_one();
        alloc_one();

        free_one(32'h0);
        free_one(32'h800);
        alloc_with_free(32'h1000);
        alloc_one();
        alloc_one();
        alloc_with_free(32'h1800);

        req_val = 1'b1;
        cycle();
        req_val = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) begin
                free_val  = 1'b1;
                free_addr = 32'h0;
            end
            cycle();
            free_val = 1'b0;
        end
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;

        free_one(32'h801);
        free_one(32'h2000);
        free_one(32'h800);
        free_one(32'h1000);
        free_one(32'h1800);
        free_one(32'h0);
        repeat (2) cycle();

        req_val = 1'b1;
        cycle();
        req_val = 1'b0;
        cycle();
        async_reset();
        repeat (6) cycle();

        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) async_reset();
            req_val  = ($urandom_range(0, 1) == 1);
            resp_rdy = ($urandom_range(0, 3) != 0);
            free_val = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       free_addr = $urandom_range(0, NB * BB - 1);
                1:       free_addr = $urandom();
                default: free_addr = $urandom_range(0, NB - 1) * BB;
            endcase
            cycle();
        end
        clear_inputs();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
